// File: rtl/mult_sequencer.sv
// Tick-enabled load/multiply sequencer: clock divider, button synchronizers,
// edge detectors, LOAD/MULT phase counters and a four-state control FSM.
module mult_sequencer #(
  parameter int unsigned DIV         = 200000,
  parameter int unsigned LOAD_CYCLES = 6,
  parameter int unsigned MULT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       btn_center,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       tick,
  output logic       clk_out,
  output logic       start,
  output logic       load_data,
  output logic       mult_active,
  output logic       load_done,
  output logic       mult_done,
  output logic       scroll_left,
  output logic       scroll_right,
  output logic [1:0] state
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic [DW-1:0] div_q, div_d;
  logic          clk_out_q, clk_out_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    btn_edge;
  logic [3:0]    load_cnt_q, load_cnt_d;
  logic [4:0]    mult_cnt_q, mult_cnt_d;
  state_e        state_q, state_d;

  // Bit order for the button vectors: {right, left, center}
  always_comb begin
    tick      = (div_q == DW'(DIV - 1));
    div_d     = tick ? '0 : div_q + DW'(1);
    clk_out_d = tick ? ~clk_out_q : clk_out_q;
    sync1_d   = sync1_q;
    sync2_d   = sync2_q;
    prev_d    = prev_q;
    if (tick) begin
      sync1_d = {btn_right, btn_left, btn_center};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
    end
  end

  assign btn_edge     = sync2_q & ~prev_q;
  assign start        = btn_edge[0];
  assign load_data    = (state_q == S_LOAD);
  assign mult_active  = (state_q == S_MULT);
  assign load_done    = load_data   && (load_cnt_q == 4'(LOAD_CYCLES - 1));
  assign mult_done    = mult_active && (mult_cnt_q == 5'(MULT_CYCLES - 1));
  assign scroll_left  = (state_q == S_DONE) && btn_edge[1];
  assign scroll_right = (state_q == S_DONE) && btn_edge[2];
  assign clk_out      = clk_out_q;
  assign state        = state_q;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    mult_cnt_d = mult_cnt_q;
    if (tick) begin
      if (clr) begin
        state_d    = S_IDLE;
        load_cnt_d = '0;
        mult_cnt_d = '0;
      end else begin
        load_cnt_d = (load_data && !load_done) ? load_cnt_q + 4'd1 : '0;
        mult_cnt_d = (mult_active && !mult_done) ? mult_cnt_q + 5'd1 : '0;
        case (state_q)
          S_IDLE: if (start)     state_d = S_LOAD;
          S_LOAD: if (load_done) state_d = S_MULT;
          S_MULT: if (mult_done) state_d = S_DONE;
          S_DONE: if (start)     state_d = S_LOAD;
          default:               state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      clk_out_q  <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      load_cnt_q <= '0;
      mult_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      div_q      <= div_d;
      clk_out_q  <= clk_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      load_cnt_q <= load_cnt_d;
      mult_cnt_q <= mult_cnt_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer at DIV=4: per-tick vector table plus
// hand-written checks for divider timing and asynchronous reset.
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic btn_center = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic tick, clk_out, start, load_data, mult_active, load_done, mult_done;
  logic scroll_left, scroll_right;
  logic [1:0] state;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  mult_sequencer #(.DIV(4), .LOAD_CYCLES(6), .MULT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .btn_center(btn_center), .btn_left(btn_left), .btn_right(btn_right),
    .tick(tick), .clk_out(clk_out), .start(start),
    .load_data(load_data), .mult_active(mult_active),
    .load_done(load_done), .mult_done(mult_done),
    .scroll_left(scroll_left), .scroll_right(scroll_right), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic clr, bc, bl, br;
    logic [1:0] st;
    logic ldd, mld, stt, sl, sr;
  } vec_t;

  vec_t vecs [64];
  int unsigned nrows = 0;

  function automatic logic [10:0] all_outs();
    return {tick, clk_out, state, load_data, mult_active, load_done,
            mult_done, start, scroll_left, scroll_right};
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int unsigned n, input logic c, input logic bc,
                     input logic bl, input logic br, input logic [1:0] st,
                     input logic ldd, input logic mld, input logic stt,
                     input logic sl, input logic sr);
    vecs[nrows] = '{n, c, bc, bl, br, st, ldd, mld, stt, sl, sr};
    nrows++;
  endtask

  // Advance to just after the next tick-qualified clock edge.
  task automatic step_tick();
    int n = 0;
    @(negedge clk);
    while (!tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!tick) begin
      nvec++;
      nmis++;
      $display("FAIL tick_timeout: got tick=0 expected tick=1 within 16 clks");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic first_tick_check(input string nm);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk({nm, "_pre"}, {10'b0, tick}, 11'd0);
    @(posedge clk);
    #1 chk({nm, "_first"}, {10'b0, tick}, 11'd1);
  endtask

  initial begin
    logic co;
    logic [8:0] act9, exp9;

    // Main run: IDLE -> LOAD(6) -> MULT(16) -> DONE with held button
    add(1, 0,1,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,1,0,0, 2'd0, 0,0,1,0,0);
    add(1, 0,1,0,0, 2'd1, 0,0,0,0,0);
    add(4, 0,1,0,0, 2'd1, 0,0,0,0,0);
    add(1, 0,1,0,0, 2'd1, 1,0,0,0,0);
    add(12,0,1,0,0, 2'd2, 0,0,0,0,0);
    add(1, 0,0,1,0, 2'd2, 0,0,0,0,0);
    add(2, 0,0,0,0, 2'd2, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd2, 0,1,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,0,0,0);
    // Scroll pulses in DONE: left alone, then both together
    add(1, 0,0,1,0, 2'd3, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,0,1,0);
    add(1, 0,0,0,0, 2'd3, 0,0,0,0,0);
    add(1, 0,0,1,1, 2'd3, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,0,1,1);
    add(1, 0,0,0,0, 2'd3, 0,0,0,0,0);
    // DONE -> LOAD on start, then clr at MULT tick 8
    add(1, 0,1,0,0, 2'd3, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,1,0,0);
    add(1, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(4, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd1, 1,0,0,0,0);
    add(7, 0,0,0,0, 2'd2, 0,0,0,0,0);
    add(1, 1,0,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd0, 0,0,0,0,0);
    // Full re-run after clr
    add(1, 0,1,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd0, 0,0,1,0,0);
    add(1, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(4, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd1, 1,0,0,0,0);
    add(15,0,0,0,0, 2'd2, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd2, 0,1,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,0,0,0);
    // clr beats start in DONE, then clr beats load_done in LOAD
    add(1, 0,1,0,0, 2'd3, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd3, 0,0,1,0,0);
    add(1, 1,0,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,1,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd0, 0,0,1,0,0);
    add(1, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(4, 0,0,0,0, 2'd1, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd1, 1,0,0,0,0);
    add(1, 1,0,0,0, 2'd0, 0,0,0,0,0);
    // Enter LOAD again for the mid-LOAD reset
    add(1, 0,1,0,0, 2'd0, 0,0,0,0,0);
    add(1, 0,0,0,0, 2'd0, 0,0,1,0,0);
    add(3, 0,0,0,0, 2'd1, 0,0,0,0,0);

    #1 chk("reset_outputs", all_outs(), 11'd0);
    first_tick_check("release");

    co = clk_out;
    @(posedge clk);
    #1 chk("clk_out_toggle", {9'b0, clk_out, tick}, {9'b0, ~co, 1'b0});
    repeat (2) @(posedge clk);
    #1 chk("tick_gap", {10'b0, tick}, 11'd0);
    @(posedge clk);
    #1 chk("tick_period", {9'b0, clk_out, tick}, {9'b0, ~co, 1'b1});
    @(posedge clk);
    #1 chk("clk_out_period", {10'b0, clk_out}, {10'b0, co});

    for (int r = 0; r < int'(nrows); r++) begin
      for (int k = 0; k < int'(vecs[r].n); k++) begin
        clr = vecs[r].clr;
        btn_center = vecs[r].bc;
        btn_left = vecs[r].bl;
        btn_right = vecs[r].br;
        step_tick();
        act9 = {state, load_data, mult_active, load_done, mult_done,
                start, scroll_left, scroll_right};
        exp9 = {vecs[r].st, vecs[r].st == 2'd1, vecs[r].st == 2'd2,
                vecs[r].ldd, vecs[r].mld, vecs[r].stt, vecs[r].sl, vecs[r].sr};
        chk($sformatf("row%0d.%0d", r, k), {2'b0, act9}, {2'b0, exp9});
      end
    end
    clr = 1'b0;
    btn_center = 1'b0;

    // Asynchronous reset mid-LOAD: outputs drop without a clock edge
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid_load", all_outs(), 11'd0);
    first_tick_check("rerelease");
    for (int k = 0; k < 3; k++) begin
      step_tick();
      chk($sformatf("post_rst%0d", k), {2'b0, all_outs() & 11'h1ff}, 11'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL use a single clock `clk`; reset is asynchronous and active-low on port `rst`, where 0 means reset.
REQ-002 SHALL have parameter DIV, default 200000: number of clk cycles per tick.
REQ-003 SHALL have parameter LOAD_CYCLES, default 6: number of ticks spent in LOAD.
REQ-004 SHALL have parameter MULT_CYCLES, default 16: number of ticks spent in MULT.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear, sampled on tick.
REQ-008 SHALL have ports btn_center, btn_left and btn_right, inputs, 1 bit each: raw, asynchronous push buttons.
REQ-009 SHALL have port tick, output, 1 bit: one-clk pulse every DIV clks.
REQ-010 SHALL have port clk_out, output, 1 bit: divided square wave that toggles on each tick.
REQ-011 SHALL have port start, output, 1 bit: one-tick pulse on a btn_center rising edge.
REQ-012 SHALL have ports load_data and mult_active, outputs, 1 bit each: Moore flags for the LOAD and MULT states.
REQ-013 SHALL have ports load_done and mult_done, outputs, 1 bit each: terminal-count flags of the phase counters.
REQ-014 SHALL have ports scroll_left and scroll_right, outputs, 1 bit each: one-tick pulses that are active only in DONE.
REQ-015 SHALL have port state, output, 2 bits: IDLE=0, LOAD=1, MULT=2, DONE=3.

Function
REQ-016 Divider SHALL count clk cycles 0..DIV-1 and wrap to 0.
REQ-017 tick SHALL be 1 exactly when the divider count equals DIV-1; clk_out SHALL then have a period of 2*DIV clks.
REQ-018 Every register other than the divider SHALL update only on clk edges where tick=1, giving a single clock domain with a clock enable and no derived clocks.
REQ-019 Each button SHALL pass through a 2-flop synchronizer clocked on tick.
REQ-020 start, scroll_left and scroll_right SHALL each be synchronized-level AND NOT previous-synchronized-level, and SHALL be high for exactly one tick period.
REQ-021 A held button SHALL produce only one pulse.
REQ-022 Load counter SHALL be 4 bits, increment on each tick while load_data=1, and be held at 0 otherwise.
REQ-023 load_done SHALL equal (load_data AND count==LOAD_CYCLES-1); the load counter SHALL wrap to 0 on that tick.
REQ-024 Mult counter SHALL be 5 bits, increment on each tick while mult_active=1, and be held at 0 otherwise.
REQ-025 mult_done SHALL equal (mult_active AND count==MULT_CYCLES-1); the mult counter SHALL wrap to 0 on that tick.
REQ-026 FSM transitions SHALL be evaluated on tick: IDLE->LOAD when start=1; LOAD->MULT when load_done=1; MULT->DONE when mult_done=1; DONE->LOAD when start=1.
REQ-027 All states not listed in REQ-026 SHALL hold.
REQ-028 LOAD SHALL last exactly LOAD_CYCLES ticks and MULT SHALL last exactly MULT_CYCLES ticks.
REQ-029 start SHALL be ignored in LOAD and MULT.
REQ-030 load_data SHALL be (state==LOAD) and mult_active SHALL be (state==MULT).
REQ-031 In DONE, scroll_left and scroll_right SHALL forward the left and right edge pulses; outside DONE they SHALL be 0.
REQ-032 If both scroll edges occur in the same tick, both outputs SHALL pulse.
REQ-033 clr=1 on a tick SHALL force state to IDLE and both counters to 0; clr SHALL have priority over start and over the done flags.
REQ-034 clr SHALL NOT affect the divider or the synchronizers.

Reset
REQ-035 rst=0 SHALL immediately clear the divider count, clk_out, both counters, the synchronizers and the edge registers, and SHALL force state to IDLE.
REQ-036 During reset every output SHALL be 0.
REQ-037 Reset asserted mid-LOAD or mid-MULT SHALL abort the operation with no residual pulse.
REQ-038 After rst goes high, the first tick SHALL occur DIV clks later.

Verification
REQ-039 With DIV=4 and rst released: tick SHALL pulse every 4 clks, and clk_out SHALL toggle every 4 clks (period 8).
REQ-040 With DIV=4, btn_center held high for 20 ticks: exactly one start pulse; state IDLE->LOAD; load_data high for 6 ticks; mult_active high for 16 ticks; then DONE.
REQ-041 After the sequence in REQ-040: load_done high only on LOAD tick 6, and mult_done high only on MULT tick 16; counters read 0 in DONE.
REQ-042 In MULT, btn_left pulse -> scroll_left stays 0; in DONE, btn_left pulse -> one scroll_left tick pulse; btn_left and btn_right together -> both outputs pulse.
REQ-043 clr=1 at MULT tick 8 -> state IDLE and mult counter 0 on the next tick; a new start re-runs the full 6+16 tick sequence.
REQ-044 rst=0 mid-LOAD -> all outputs 0 immediately, with no clk edge needed.
